// File: rtl/l1_l2_pkg.sv
// Shared L1->L2 request encodings: command codes, source ids and line address width.
package l1_l2_pkg;

    localparam int ADDR_W = 26;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_RFO   = 2'b11
    } l2_cmd_e;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    localparam int NUM_SRC = 2;

endpackage

// File: rtl/l2_req_fifo.sv
// Synchronous request FIFO; full/empty derive from the registered occupancy count,
// so a full queue refuses a push even in a cycle where it also pops.
module l2_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Arbitrates the I- and D-cache request queues onto the single L2 command bus
// (writeback priority, otherwise round-robin) and keeps grant/stall statistics.
module l2_request_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = l1_l2_pkg::ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_cmd,
    output logic              i_req_ready,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [1:0]        d_req_cmd,
    output logic              d_req_ready,
    output logic [ADDR_W-1:0] addr_to_L2,
    output logic [1:0]        command_to_L2,
    output logic              l2_src,
    output logic              l2_valid,
    input  logic              l2_ready,
    output logic [31:0]       grant_i_count,
    output logic [31:0]       grant_d_count,
    output logic [31:0]       stall_count,
    output logic [31:0]       bad_cmd_count
);
    import l1_l2_pkg::*;

    localparam int EW = ADDR_W + 2;

    typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

    state_e state, state_nxt;

    logic [NUM_SRC-1:0]         f_push, f_pop, f_full, f_empty;
    logic [NUM_SRC-1:0][EW-1:0] f_din, f_head;

    logic rr_ptr;       // last granted source; the other side wins a tie
    logic any_pending;
    logic issue_done;
    logic load;
    logic sel_d;
    logic i_bad;

    // Entry layout: {cmd, addr}
    assign f_din[SRC_I] = {i_req_cmd, i_req_addr};
    assign f_din[SRC_D] = {d_req_cmd, d_req_addr};

    assign i_req_ready = ~f_full[SRC_I];
    assign d_req_ready = ~f_full[SRC_D];

    // The I side only issues fills; anything else is dropped and counted.
    assign i_bad         = i_req_valid & i_req_ready & (i_req_cmd != CMD_READ);
    assign f_push[SRC_I] = i_req_valid & (i_req_cmd == CMD_READ);
    assign f_push[SRC_D] = d_req_valid & (d_req_cmd != CMD_NOP);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
        l2_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (EW)
        ) u_fifo (
            .Clock (Clock),
            .Reset (Reset),
            .push  (f_push[s]),
            .din   (f_din[s]),
            .pop   (f_pop[s]),
            .head  (f_head[s]),
            .full  (f_full[s]),
            .empty (f_empty[s])
        );
    end

    assign l2_valid = (state == ST_ISSUE);

    always_comb begin
        state_nxt   = state;
        any_pending = ~f_empty[SRC_I] | ~f_empty[SRC_D];
        issue_done  = l2_valid & l2_ready;
        load        = any_pending & ((state == ST_IDLE) | issue_done);
        // Writeback at the D head beats a pending fill regardless of the pointer.
        sel_d       = ~f_empty[SRC_D] &
                      (f_empty[SRC_I] | (f_head[SRC_D][EW-1 -: 2] == CMD_WRITE) | (rr_ptr == SRC_I));
        f_pop       = '0;
        f_pop[SRC_D] = load & sel_d;
        f_pop[SRC_I] = load & ~sel_d;
        case (state)
            ST_IDLE:  if (any_pending) state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue_done & ~any_pending) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= SRC_I;
            addr_to_L2    <= '0;
            command_to_L2 <= CMD_NOP;
            l2_src        <= SRC_I;
        end else begin
            state <= state_nxt;
            if (load) begin
                rr_ptr        <= sel_d;
                l2_src        <= sel_d;
                addr_to_L2    <= f_head[sel_d][ADDR_W-1:0];
                command_to_L2 <= f_head[sel_d][EW-1 -: 2];
            end else if (issue_done) begin
                command_to_L2 <= CMD_NOP;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            grant_i_count <= '0;
            grant_d_count <= '0;
            stall_count   <= '0;
            bad_cmd_count <= '0;
        end else begin
            if (issue_done & (l2_src == SRC_I)) grant_i_count <= grant_i_count + 32'd1;
            if (issue_done & (l2_src == SRC_D)) grant_d_count <= grant_d_count + 32'd1;
            if (l2_valid & ~l2_ready)           stall_count   <= stall_count + 32'd1;
            if (i_bad)                          bad_cmd_count <= bad_cmd_count + 32'd1;
        end
    end

endmodule
